reg_bank_arbiter: RTL
=====================

// Module: reg_bank_arbiter
// PURPOSE
//  Shares the single-port register bank (`top`) between two requesters, A and B.
//  Arbitrates round-robin, sequences one bank transaction at a time and returns read data per requester.
//  Rejects out-of-range addresses before they reach the bank.
//  Sits between the two requesters and the bank's write_en/read_en/addr/data_in/data_out port.
// PARAMETERS
//  DATA_W      16  data width
//  ADDR_W      4   address width
//  NUM_REGS    14  implemented registers; addr >= NUM_REGS is invalid
//  RD_LATENCY  1   cycles from bank_read_en sampled to bank_data_out valid (>=1)
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       asynchronous reset, active-high
//  req_a/req_b    in   1       request; held with we/addr/wdata stable until ack
//  we_a/we_b      in   1       1=write, 0=read
//  addr_a/addr_b  in   ADDR_W  register address
//  wdata_a/wdata_b in  DATA_W  write data
//  ack_a/ack_b    out  1       1-cycle completion pulse
//  err_a/err_b    out  1       valid with ack; 1 = invalid address
//  rdata_a/rdata_b out DATA_W  read data; valid with ack, holds until next ack to that side
//  bank_write_en  out  1       to bank write_en
//  bank_read_en   out  1       to bank read_en
//  bank_addr      out  ADDR_W  to bank addr
//  bank_data_in   out  DATA_W  to bank data_in
//  bank_data_out  in   DATA_W  from bank data_out
//  busy           out  1       high in any state other than IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE; all outputs 0; rdata_a/b=0; last_grant=B (A wins first tie).
//  FSM IDLE -> ISSUE -> [WAIT] -> ACK -> IDLE. One transaction in flight.
//  IDLE: sample req_a/req_b. Only one high -> grant it. Both high -> grant the side != last_grant.
//    On grant, latch we/addr/wdata, update last_grant, go to ISSUE. No req -> stay.
//  ISSUE (1 cycle): addr valid & write -> bank_write_en=1 this cycle only -> ACK.
//    addr valid & read -> bank_read_en=1 this cycle only -> WAIT.
//    addr invalid -> no bank enable -> ACK with err=1, rdata=0.
//  WAIT: counts RD_LATENCY cycles. Captures bank_data_out at the last WAIT edge -> ACK.
//  ACK (1 cycle): ack and err of the granted side only; rdata of that side updated for reads. -> IDLE.
//  bank_addr/bank_data_in hold the latched values from ISSUE through ACK; 0 in IDLE.
//  Latency from the edge that samples req: write/invalid ack after 2 cycles; read ack after 2+RD_LATENCY cycles.
//  Requester drops req on the edge where ack is seen. A req still high in IDLE after ACK is a new request.
//  Losing requester keeps req high and waits. Starvation-free: max wait is one transaction of the other side.
//  req changing while not granted: no effect until IDLE. Inputs of the granted side are ignored after latching.
//  bank_write_en and bank_read_en are never high together. Never high for invalid addresses.
//  rst mid-transaction: abort to IDLE. No ack. Enables drop immediately. Requesters must re-request.
//  rst also resets the bank (shared rst). Arbiter holds no register shadow.
// TESTING
//  1. rst; req_a write addr 3 = 16'hBEEF -> bank_write_en 1 cycle, addr 3; ack_a 2 cycles later, err_a=0.
//  2. req_a read addr 3 after (1) -> bank_read_en 1 cycle; ack_a at 2+RD_LATENCY; rdata_a=16'hBEEF.
//  3. req_a and req_b both held from reset (A wr 0=16'h1111, B wr 1=16'h2222), re-request 3 times -> grants A,B,A,B,A,B; no back-to-back same side.
//  4. req_b write addr 14 = 16'hDEAD, then read addr 15 -> no bank enables; ack_b with err_b=1, rdata_b=0; reg 14/15 unchanged.
//  5. Assert rst during WAIT of a read by A -> outputs 0 same cycle; no ack_a; next tie grants A.
//  6. Random: 200 mixed A/B transactions vs. a model of 14x16 regs -> all rdata match; write/read enables never overlap.

Source files
------------

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter sharing one single-port register bank between requesters A and B.
// One transaction in flight; out-of-range addresses are answered with err and never reach the bank.
module reg_bank_arbiter #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 4,
  parameter int NUM_REGS   = 14,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              ack_a,
  output logic              err_a,
  output logic [DATA_W-1:0] rdata_a,
  output logic              ack_b,
  output logic              err_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic              bank_write_en,
  output logic              bank_read_en,
  output logic [ADDR_W-1:0] bank_addr,
  output logic [DATA_W-1:0] bank_data_in,
  input  logic [DATA_W-1:0] bank_data_out,
  output logic              busy
);
  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RD_LATENCY - 1);
  localparam logic [ADDR_W:0]   ADDR_LIM = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t            state, state_nxt;
  logic              last_grant;   // 0 = A, 1 = B
  logic              side;         // side currently being served
  logic              lat_we, lat_inv;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [CNT_W-1:0]  cnt;
  logic              grant_a, grant_b, inv_a, inv_b;

  // On a tie the side that did not win last time gets the bank.
  assign grant_a = req_a & (~req_b | last_grant);
  assign grant_b = req_b & ~grant_a;
  assign inv_a   = {1'b0, addr_a} >= ADDR_LIM;
  assign inv_b   = {1'b0, addr_b} >= ADDR_LIM;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bank_write_en = 1'b0;
    bank_read_en  = 1'b0;
    ack_a         = 1'b0;
    ack_b         = 1'b0;
    err_a         = 1'b0;
    err_b         = 1'b0;
    case (state)
      IDLE:  if (grant_a | grant_b) state_nxt = ISSUE;
      ISSUE: begin
        bank_write_en = lat_we & ~lat_inv;
        bank_read_en  = ~lat_we & ~lat_inv;
        state_nxt     = (lat_we | lat_inv) ? ACK : WAIT;
      end
      WAIT:  if (cnt == CNT_LAST) state_nxt = ACK;
      ACK: begin
        ack_a     = ~side;
        ack_b     = side;
        err_a     = ~side & lat_inv;
        err_b     = side & lat_inv;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Enables are combinational from state so an async reset drops them at once.
  assign busy         = (state != IDLE);
  assign bank_addr    = busy ? lat_addr : '0;
  assign bank_data_in = busy ? lat_wdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      side       <= 1'b0;
      lat_we     <= 1'b0;
      lat_inv    <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      cnt        <= '0;
      rdata_a    <= '0;
      rdata_b    <= '0;
    end else begin
      case (state)
        IDLE: if (grant_a | grant_b) begin
          side       <= grant_b;
          last_grant <= grant_b;
          lat_we     <= grant_b ? we_b    : we_a;
          lat_addr   <= grant_b ? addr_b  : addr_a;
          lat_wdata  <= grant_b ? wdata_b : wdata_a;
          lat_inv    <= grant_b ? inv_b   : inv_a;
        end
        ISSUE: begin
          cnt <= '0;
          if (lat_inv) begin
            if (side) rdata_b <= '0;
            else      rdata_a <= '0;
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            if (side) rdata_b <= bank_data_out;
            else      rdata_a <= bank_data_out;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
